// File: rtl/if_stage.sv
// Instruction-fetch stage with req/ack instruction memory, IF/ID register and a stall skid.
// Optional IF_DELAY_SLOT_EN: keep the sequential instruction after a redirect (MIPS delay slot).
`timescale 1ns/1ps
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic        jumpD,
  input  logic [31:0] pcchangeD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pcF,
  output logic [31:0] irD,
  output logic [31:0] pcplusD,
  output logic        validD
);

  typedef enum logic [1:0] {FETCH, DROP, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pcplus_q, pcplus_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] skid_pcplus_q, skid_pcplus_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        valid_q, valid_d;
  logic        stale_q, stale_d;
  logic        req_pend_q, req_pend_d;
`ifdef IF_DELAY_SLOT_EN
  logic        pending_q, pending_d;
`endif

  logic        ack_eff;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus;
  logic [31:0] pc_seq;

  // An ack that answers a request issued before reset belongs to nobody.
  assign ack_eff   = imem_ack & ~stale_q;
  assign redirect  = (pcsrcD | jumpD) & valid_q & ~stallD;
  assign target    = pcchangeD & ~32'h0000_0003;
  assign pc_plus   = pc_q + 32'd4;
`ifdef IF_DELAY_SLOT_EN
  assign pc_seq    = pending_q ? redir_pc_q : pc_plus;
`else
  assign pc_seq    = pc_plus;
`endif

  assign imem_req  = rst_n & (state_q != HOLD);
  assign imem_addr = pc_q;
  assign pcF       = pc_q;
  assign irD       = ir_q;
  assign pcplusD   = pcplus_q;
  assign validD    = valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    pcplus_d      = pcplus_q;
    valid_d       = valid_q;
    skid_ir_d     = skid_ir_q;
    skid_pcplus_d = skid_pcplus_q;
    redir_pc_d    = redir_pc_q;
    req_pend_d    = imem_req & ~ack_eff;
    stale_d       = rst_n ? (stale_q & ~imem_ack) : ((stale_q | req_pend_q) & ~imem_ack);
`ifdef IF_DELAY_SLOT_EN
    pending_d     = pending_q;
`endif
    case (state_q)
      FETCH: begin
        if (redirect) begin
`ifdef IF_DELAY_SLOT_EN
          if (ack_eff) begin
            ir_d     = imem_rdata;
            pcplus_d = pc_plus;
            valid_d  = 1'b1;
            pc_d     = target;
          end else begin
            pending_d  = 1'b1;
            redir_pc_d = target;
            ir_d       = NOP_INSTR;
            valid_d    = 1'b0;
          end
`else
          ir_d    = NOP_INSTR;
          valid_d = 1'b0;
          if (ack_eff) begin
            pc_d = target;
          end else begin
            redir_pc_d = target;
            state_d    = DROP;
          end
`endif
        end else if (ack_eff) begin
          pc_d = pc_seq;
`ifdef IF_DELAY_SLOT_EN
          pending_d = 1'b0;
`endif
          if (stallD) begin
            skid_ir_d     = imem_rdata;
            skid_pcplus_d = pc_plus;
            state_d       = HOLD;
          end else begin
            ir_d     = imem_rdata;
            pcplus_d = pc_plus;
            valid_d  = 1'b1;
          end
        end else if (!stallD) begin
          ir_d    = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      DROP: begin
        if (!stallD) begin
          ir_d    = NOP_INSTR;
          valid_d = 1'b0;
        end
        if (ack_eff) begin
          pc_d    = redir_pc_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (!stallD) begin
          state_d = FETCH;
          if (redirect) begin
            pc_d = target;
`ifdef IF_DELAY_SLOT_EN
            ir_d     = skid_ir_q;
            pcplus_d = skid_pcplus_q;
            valid_d  = 1'b1;
`else
            ir_d    = NOP_INSTR;
            valid_d = 1'b0;
`endif
          end else begin
            ir_d     = skid_ir_q;
            pcplus_d = skid_pcplus_q;
            valid_d  = 1'b1;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= NOP_INSTR;
      pcplus_q      <= 32'h0;
      valid_q       <= 1'b0;
      skid_ir_q     <= NOP_INSTR;
      skid_pcplus_q <= 32'h0;
      redir_pc_q    <= 32'h0;
      req_pend_q    <= 1'b0;
      stale_q       <= stale_d;
`ifdef IF_DELAY_SLOT_EN
      pending_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      pcplus_q      <= pcplus_d;
      valid_q       <= valid_d;
      skid_ir_q     <= skid_ir_d;
      skid_pcplus_q <= skid_pcplus_d;
      redir_pc_q    <= redir_pc_d;
      req_pend_q    <= req_pend_d;
      stale_q       <= stale_d;
`ifdef IF_DELAY_SLOT_EN
      pending_q     <= pending_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model with programmable latency, per-scenario tasks.
`timescale 1ns/1ps
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallD = 1'b0;
  logic        pcsrcD = 1'b0;
  logic        jumpD = 1'b0;
  logic [31:0] pcchangeD = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] pcF;
  logic [31:0] irD;
  logic [31:0] pcplusD;
  logic        validD;

  int checks = 0;
  int passes = 0;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  if_stage #(.RESET_PC(32'h0000_3000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stallD(stallD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .pcchangeD(pcchangeD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pcF(pcF), .irD(irD),
    .pcplusD(pcplusD), .validD(validD)
  );

  always #5 clk = ~clk;

  // Memory answers addr+0x1000_0000 after mem_lat cycles; it keeps serving through reset.
  int          mem_lat = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  bit          addr_moved = 1'b0;

  always @(negedge clk) begin
    if (imem_ack) mem_busy = 1'b0;
    if (mem_busy) begin
      mem_cnt++;
      if (imem_req && imem_addr !== mem_addr) addr_moved = 1'b1;
    end else if (imem_req) begin
      mem_busy = 1'b1;
      mem_cnt  = 1;
      mem_addr = imem_addr;
    end
    if (mem_busy && mem_cnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_addr + 32'h1000_0000;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    rst_n = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0; pcchangeD = 32'h0;
    repeat (5) step();
    mem_lat = lat;
    addr_moved = 1'b0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0) $display("[TB] FAIL rst_req: got %0h want 0", imem_req); else passes++;
    repeat (4) step();
    checks++; if (pcF !== 32'h3000) $display("[TB] FAIL rst_pc: got %h want 00003000", pcF); else passes++;
    checks++; if (validD !== 1'b0) $display("[TB] FAIL rst_valid: got %0h want 0", validD); else passes++;
    checks++; if (irD !== 32'h0) $display("[TB] FAIL rst_ir: got %h want 00000000", irD); else passes++;
    checks++; if (pcplusD !== 32'h0) $display("[TB] FAIL rst_pcplus: got %h want 00000000", pcplusD); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) $display("[TB] FAIL rst_release_req: got %0h want 1", imem_req); else passes++;
  endtask

  task automatic test_sequential();
    do_reset(1);
    checks++; if (imem_addr !== 32'h3000) $display("[TB] FAIL seq_addr0: got %h want 00003000", imem_addr); else passes++;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h3000 + 4*i) $display("[TB] FAIL seq_addr%0d: got %h want %h", i, imem_addr, 32'h3000 + 4*i); else passes++;
      checks++; if (irD !== 32'h1000_3000 + 4*(i-1)) $display("[TB] FAIL seq_ir%0d: got %h want %h", i, irD, 32'h1000_3000 + 4*(i-1)); else passes++;
      checks++; if (pcplusD !== 32'h3000 + 4*i) $display("[TB] FAIL seq_pcplus%0d: got %h want %h", i, pcplusD, 32'h3000 + 4*i); else passes++;
      checks++; if (validD !== 1'b1) $display("[TB] FAIL seq_valid%0d: got %0h want 1", i, validD); else passes++;
    end
  endtask

  task automatic test_latency();
    logic        ev;
    logic [31:0] eir, eaddr;
    do_reset(3);
    for (int i = 1; i <= 6; i++) begin
      step();
      ev    = (i % 3 == 0);
      eir   = ev ? 32'h1000_3000 + 4*(i/3 - 1) : 32'h0;
      eaddr = 32'h3000 + 4*(i/3);
      checks++; if (validD !== ev) $display("[TB] FAIL lat_valid%0d: got %0h want %0h", i, validD, ev); else passes++;
      checks++; if (irD !== eir) $display("[TB] FAIL lat_ir%0d: got %h want %h", i, irD, eir); else passes++;
      checks++; if (imem_addr !== eaddr) $display("[TB] FAIL lat_addr%0d: got %h want %h", i, imem_addr, eaddr); else passes++;
    end
    checks++; if (addr_moved !== 1'b0) $display("[TB] FAIL lat_addr_stable: got %0h want 0", addr_moved); else passes++;
  endtask

  task automatic test_stall();
    do_reset(1);
    step();
    checks++; if (irD !== 32'h1000_3000) $display("[TB] FAIL stall_pre_ir: got %h want 10003000", irD); else passes++;
    stallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (irD !== 32'h1000_3000) $display("[TB] FAIL stall_ir%0d: got %h want 10003000", i, irD); else passes++;
      checks++; if (pcplusD !== 32'h3004) $display("[TB] FAIL stall_pcplus%0d: got %h want 00003004", i, pcplusD); else passes++;
      checks++; if (imem_req !== 1'b0) $display("[TB] FAIL stall_req%0d: got %0h want 0", i, imem_req); else passes++;
    end
    stallD = 1'b0;
    step();
    checks++; if (irD !== 32'h1000_3004) $display("[TB] FAIL stall_skid_ir: got %h want 10003004", irD); else passes++;
    checks++; if (pcplusD !== 32'h3008) $display("[TB] FAIL stall_skid_pcplus: got %h want 00003008", pcplusD); else passes++;
    checks++; if (validD !== 1'b1) $display("[TB] FAIL stall_skid_valid: got %0h want 1", validD); else passes++;
    checks++; if (imem_addr !== 32'h3008) $display("[TB] FAIL stall_resume_addr: got %h want 00003008", imem_addr); else passes++;
    step();
    checks++; if (irD !== 32'h1000_3008) $display("[TB] FAIL stall_next_ir: got %h want 10003008", irD); else passes++;
    checks++; if (pcplusD !== 32'h300C) $display("[TB] FAIL stall_next_pcplus: got %h want 0000300c", pcplusD); else passes++;
  endtask

  task automatic test_branch();
    do_reset(1);
    step();
    pcsrcD = 1'b1; pcchangeD = 32'h0000_0040;
    step();
    pcsrcD = 1'b0;
    checks++; if (imem_addr !== 32'h40) $display("[TB] FAIL br_addr: got %h want 00000040", imem_addr); else passes++;
    checks++; if (validD !== DS) $display("[TB] FAIL br_valid: got %0h want %0h", validD, DS); else passes++;
    checks++; if (irD !== (DS ? 32'h1000_3004 : 32'h0)) $display("[TB] FAIL br_ir: got %h want %h", irD, DS ? 32'h1000_3004 : 32'h0); else passes++;
    step();
    checks++; if (irD !== 32'h1000_0040) $display("[TB] FAIL br_target_ir: got %h want 10000040", irD); else passes++;
    checks++; if (pcplusD !== 32'h44) $display("[TB] FAIL br_target_pcplus: got %h want 00000044", pcplusD); else passes++;
    checks++; if (imem_addr !== 32'h44) $display("[TB] FAIL br_next_addr: got %h want 00000044", imem_addr); else passes++;
  endtask

  task automatic test_jump_drop();
    do_reset(3);
    repeat (3) step();
    checks++; if (validD !== 1'b1) $display("[TB] FAIL jmp_pre_valid: got %0h want 1", validD); else passes++;
    jumpD = 1'b1; pcchangeD = 32'h0000_0100;
    step();
    jumpD = 1'b0;
    checks++; if (validD !== 1'b0) $display("[TB] FAIL jmp_bubble: got %0h want 0", validD); else passes++;
    checks++; if (imem_addr !== 32'h3004) $display("[TB] FAIL jmp_hold_addr: got %h want 00003004", imem_addr); else passes++;
    checks++; if (imem_req !== 1'b1) $display("[TB] FAIL jmp_hold_req: got %0h want 1", imem_req); else passes++;
    step();
    checks++; if (imem_addr !== 32'h3004) $display("[TB] FAIL jmp_hold_addr2: got %h want 00003004", imem_addr); else passes++;
    step();
    checks++; if (imem_addr !== 32'h100) $display("[TB] FAIL jmp_target_addr: got %h want 00000100", imem_addr); else passes++;
    checks++; if (validD !== DS) $display("[TB] FAIL jmp_late_valid: got %0h want %0h", validD, DS); else passes++;
    checks++; if (irD !== (DS ? 32'h1000_3004 : 32'h0)) $display("[TB] FAIL jmp_late_ir: got %h want %h", irD, DS ? 32'h1000_3004 : 32'h0); else passes++;
    repeat (3) step();
    checks++; if (irD !== 32'h1000_0100) $display("[TB] FAIL jmp_target_ir: got %h want 10000100", irD); else passes++;
    checks++; if (pcplusD !== 32'h104) $display("[TB] FAIL jmp_target_pcplus: got %h want 00000104", pcplusD); else passes++;
  endtask

  task automatic test_stale_reset();
    do_reset(3);
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) $display("[TB] FAIL stale_req_in_reset: got %0h want 0", imem_req); else passes++;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (pcF !== 32'h3000) $display("[TB] FAIL stale_pc: got %h want 00003000", pcF); else passes++;
    step();
    checks++; if (validD !== 1'b0) $display("[TB] FAIL stale_ack_valid: got %0h want 0", validD); else passes++;
    checks++; if (irD !== 32'h0) $display("[TB] FAIL stale_ack_ir: got %h want 00000000", irD); else passes++;
    checks++; if (imem_addr !== 32'h3000) $display("[TB] FAIL stale_addr: got %h want 00003000", imem_addr); else passes++;
    repeat (2) step();
    checks++; if (validD !== 1'b0) $display("[TB] FAIL stale_wait_valid: got %0h want 0", validD); else passes++;
    step();
    checks++; if (irD !== 32'h1000_3000) $display("[TB] FAIL stale_refetch_ir: got %h want 10003000", irD); else passes++;
    checks++; if (validD !== 1'b1) $display("[TB] FAIL stale_refetch_valid: got %0h want 1", validD); else passes++;
    checks++; if (pcplusD !== 32'h3004) $display("[TB] FAIL stale_refetch_pcplus: got %h want 00003004", pcplusD); else passes++;
  endtask

  task automatic test_wrap();
    do_reset(1);
    step();
    jumpD = 1'b1; pcchangeD = 32'hFFFF_FFFF;
    step();
    jumpD = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_target_addr: got %h want fffffffc", imem_addr); else passes++;
    step();
    checks++; if (imem_addr !== 32'h0) $display("[TB] FAIL wrap_addr: got %h want 00000000", imem_addr); else passes++;
    checks++; if (pcplusD !== 32'h0) $display("[TB] FAIL wrap_pcplus: got %h want 00000000", pcplusD); else passes++;
    checks++; if (irD !== 32'h0FFF_FFFC) $display("[TB] FAIL wrap_ir: got %h want 0ffffffc", irD); else passes++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_stall();
    test_branch();
    test_jump_drop();
    test_stale_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
